// File: rtl/obi_mem_responder_pkg.sv
// Types and constants shared by the OBI memory responder and its response pipeline.
package obi_mem_responder_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } gnt_state_e;

  typedef enum logic [1:0] {
    KIND_WRITE,
    KIND_READ,
    KIND_READ_ERR
  } resp_kind_e;

  localparam logic [31:0] ERR_RDATA = 32'hBADCAB1E;

  // Response payload for a transaction once the SRAM read data is available.
  function automatic logic [31:0] resp_data(input resp_kind_e kind, input logic [31:0] mem_rdata);
    logic [31:0] data;
    case (kind)
      KIND_READ:     data = mem_rdata;
      KIND_READ_ERR: data = ERR_RDATA;
      default:       data = 32'h0;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// Shared OBI bus types used by initiators and responders in this codebase.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_resp_pipe.sv
// Fixed-latency, in-order response delay line: one rvalid per push, RESP_LATENCY cycles later.
module obi_resp_pipe
  import obi_mem_responder_pkg::*;
#(
  parameter int unsigned RESP_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  resp_kind_e  kind_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        busy_o
);

  localparam int unsigned L = RESP_LATENCY;

  logic [L-1:0] valid_q, valid_d;
  resp_kind_e   kind_q, kind_d;
  logic [31:0]  head_data;
  logic [31:0]  tail_data;

  // Stage 0 only knows the kind; SRAM data arrives while the entry sits there.
  always_comb begin
    valid_d    = '0;
    valid_d[0] = push_i;
    for (int i = 1; i < int'(L); i++) begin
      valid_d[i] = valid_q[i-1];
    end
    kind_d    = kind_i;
    head_data = resp_data(kind_q, mem_rdata_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      kind_q  <= KIND_WRITE;
    end else begin
      valid_q <= valid_d;
      kind_q  <= kind_d;
    end
  end

  if (L == 1) begin : g_direct
    assign tail_data = head_data;
  end else begin : g_delay
    logic [31:0] data_q [L-1];
    logic [31:0] data_d [L-1];

    always_comb begin
      data_d[0] = head_data;
      for (int i = 1; i < int'(L) - 1; i++) begin
        data_d[i] = data_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(L) - 1; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        data_q <= data_d;
      end
    end

    assign tail_data = data_q[L-2];
  end

  // Outputs are forced quiet during reset so stale entries never leak out.
  assign rvalid_o = valid_q[L-1] & ~rst_i;
  assign busy_o   = (|valid_q) & ~rst_i;
  assign rdata_o  = rvalid_o ? tail_data : 32'h0;

endmodule

// File: rtl/obi_mem_responder.sv
// OBI slave in front of a single-port SRAM with programmable grant wait and response latency.
module obi_mem_responder
  import obi_pkg::*;
  import obi_mem_responder_pkg::*;
#(
  parameter int unsigned NUM_WORDS    = 1024,
  parameter int unsigned WAIT_CYCLES  = 0,
  parameter int unsigned RESP_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  obi_req_t                     obi_req_i,
  output obi_resp_t                    obi_resp_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [$clog2(NUM_WORDS)-1:0] mem_addr_o,
  output logic [3:0]                   mem_be_o,
  output logic [31:0]                  mem_wdata_o,
  input  logic [31:0]                  mem_rdata_i,
  output logic                         busy_o
);

  localparam int unsigned AW       = $clog2(NUM_WORDS);
  localparam int unsigned SHIFT    = 2 + AW;
  localparam logic [3:0]  WAIT_LIM = 4'(WAIT_CYCLES);

  gnt_state_e  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        gnt;
  logic        in_range;
  resp_kind_e  kind;
  logic        rvalid;
  logic [31:0] rdata;

  // Shifting instead of slicing keeps the compare legal for any NUM_WORDS.
  assign in_range = (obi_req_i.addr >> SHIFT) == (BASE_ADDR >> SHIFT);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    gnt        = 1'b0;

    if (!rst_i && obi_req_i.req && (wait_cnt_q == WAIT_LIM)) begin
      gnt = 1'b1;
    end

    case (state_q)
      ST_IDLE: if (obi_req_i.req && !gnt) state_d = ST_WAIT;
      ST_WAIT: if (gnt || !obi_req_i.req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (gnt || !obi_req_i.req) begin
      wait_cnt_d = '0;
    end else begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    kind = KIND_WRITE;
    if (!obi_req_i.we) begin
      kind = in_range ? KIND_READ : KIND_READ_ERR;
    end
  end

  assign mem_req_o   = gnt & in_range;
  assign mem_we_o    = obi_req_i.we;
  assign mem_addr_o  = obi_req_i.addr[2 +: AW];
  assign mem_be_o    = obi_req_i.be;
  assign mem_wdata_o = obi_req_i.wdata;

  obi_resp_pipe #(
    .RESP_LATENCY(RESP_LATENCY)
  ) u_resp_pipe (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (gnt),
    .kind_i     (kind),
    .mem_rdata_i(mem_rdata_i),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .busy_o     (busy_o)
  );

  always_comb begin
    obi_resp_o        = '0;
    obi_resp_o.gnt    = gnt;
    obi_resp_o.rvalid = rvalid;
    obi_resp_o.rdata  = rdata;
  end

endmodule

// File: doc/obi_mem_responder.md
OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 Parameter NUM_WORDS, default 1024: number of 32-bit words in the backing SRAM; SHALL be a power of two, at least 2.
REQ-002 Parameter WAIT_CYCLES, default 0: number of cycles req is held high before gnt; SHALL be in the range 0..15.
REQ-003 Parameter RESP_LATENCY, default 1: cycles from the gnt cycle to the rvalid cycle; SHALL be in the range 1..4.
REQ-004 Parameter BASE_ADDR, default 32'h0: byte address of word 0; SHALL be aligned to NUM_WORDS*4.
REQ-005 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 obi_req_i  in  obi_req_t  OBI request from initiator (req, we, be, addr, wdata).
REQ-008 obi_resp_o  out  obi_resp_t  OBI response (gnt, rvalid, rdata).
REQ-009 mem_req_o  out  1  SRAM access strobe.
REQ-010 mem_we_o  out  1  SRAM write enable.
REQ-011 mem_addr_o  out  $clog2(NUM_WORDS)  SRAM word index.
REQ-012 mem_be_o  out  4  SRAM byte enables.
REQ-013 mem_wdata_o  out  32  SRAM write data.
REQ-014 mem_rdata_i  in  32  SRAM read data, valid the cycle after mem_req_o.
REQ-015 busy_o  out  1  high while any granted transaction has not yet produced rvalid.

Function
REQ-016 The grant FSM SHALL have two states: IDLE and WAIT. IDLE goes to WAIT when req=1, WAIT_CYCLES>0 and no grant occurs. WAIT goes to IDLE on gnt, or when req drops (protocol-violation tolerance).
REQ-017 The wait counter SHALL count cycles with req=1 and reset to 0 on gnt or when req=0; gnt SHALL assert combinationally when req=1 and counter==WAIT_CYCLES.
REQ-018 With WAIT_CYCLES=0, gnt SHALL assert in the same cycle req rises.
REQ-019 After a grant with req still high, the next request SHALL restart the wait count from 0, so back-to-back grants are WAIT_CYCLES+1 cycles apart (one per cycle when WAIT_CYCLES=0).
REQ-020 In-range test: an address is in range when addr[31:2+AW] equals BASE_ADDR[31:2+AW], where AW=$clog2(NUM_WORDS); the word index is addr[2+:AW]; addr[1:0] SHALL be ignored.
REQ-021 In-range access: mem_req_o SHALL assert only in the gnt cycle. we, be, wdata and the index SHALL pass through combinationally in that cycle.
REQ-022 Out-of-range access: it SHALL be granted normally, mem_req_o SHALL stay 0, writes SHALL be dropped, and reads SHALL return 32'hBADCAB1E.
REQ-023 Response timing: for every grant, exactly one rvalid pulse SHALL occur exactly RESP_LATENCY cycles after the gnt cycle. Responses SHALL be in order, with no backpressure.
REQ-024 rdata SHALL be mem_rdata_i (captured the cycle after gnt) for in-range reads, 32'h0 for all writes, and 32'hBADCAB1E for out-of-range reads. rdata SHALL be 32'h0 whenever rvalid=0.
REQ-025 Outstanding transactions: up to RESP_LATENCY may be outstanding. A gnt and an rvalid in the same cycle SHALL both be honoured.
REQ-026 busy_o SHALL equal the OR of all occupied response-pipeline stages.
REQ-027 gnt SHALL never assert while req=0.

Reset
REQ-028 While rst_i=1: gnt=0, rvalid=0, rdata=0, mem_req_o=0, busy_o=0, FSM=IDLE, counter=0, all pipeline stages empty.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight responses, with no rvalid for them after release.
REQ-030 gnt SHALL NOT assert in the reset cycle even if req=1; normal operation starts the cycle after rst_i falls.

Structure
REQ-031 obi_req_t and obi_resp_t SHALL come from the existing obi_pkg.
REQ-032 The FSM state enum and the 32'hBADCAB1E error constant SHALL live in a shared package, obi_mem_responder_pkg.
REQ-033 The response delay line (valid/kind/data stages) SHALL be one sub-module, obi_resp_pipe, parameterised by RESP_LATENCY.

Verification
REQ-034 WAIT_CYCLES=0, RESP_LATENCY=1: write 32'hDEADBEEF to 0x10 with be=4'hF, then read 0x10. Required: gnt on each request cycle; rvalid 1 cycle after each gnt; write rdata=0; read rdata=32'hDEADBEEF.
REQ-035 WAIT_CYCLES=3: req held at 0x0. Required: gnt exactly 3 cycles after req rises; mem_req_o only in that cycle.
REQ-036 RESP_LATENCY=3: 3 back-to-back reads of words 1, 2, 3 pre-loaded with 0x11, 0x22, 0x33. Required: 3 consecutive rvalid cycles starting 3 cycles after the first gnt, data in order; busy_o high from the first gnt until the last rvalid.
REQ-037 NUM_WORDS=1024, BASE_ADDR=0: read 0x0000_1000 and write 0x0000_1004. Required: mem_req_o=0; read rdata=32'hBADCAB1E; SRAM contents unchanged.
REQ-038 Byte-enable write: be=4'b0010 with wdata=32'hAABBCCDD over word 0x0. Required: mem_be_o=4'b0010 and the next read returns only byte 1 updated to 0xCC.
REQ-039 Reset mid-flight: rst_i=1 pulsed in the cycle after a read gnt with RESP_LATENCY=2. Required: no rvalid afterwards, busy_o=0, and the next request is granted normally.
